// File: rtl/monopulse_averager.sv
// Block averager for the monopulse relation stream: start-up discard, then one average per 2^LOG2_LEN samples.
// Optional AVG_ROUNDING_EN: round half toward +inf instead of flooring.
//
// state     | meaning
// ST_WARMUP | counting off start-up samples, nothing accumulated
// ST_ACCUM  | accumulating blocks, one average per block
module monopulse_averager #(
  parameter int          DATA_SIZE = 64,
  parameter int          LOG2_LEN  = 4,
  parameter int          DISCARD   = 8,
  parameter int unsigned THRESHOLD = 1024
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic signed [DATA_SIZE-1:0] i_relation,
  input  logic                        i_valid,
  output logic signed [DATA_SIZE-1:0] o_average,
  output logic                        o_valid,
  output logic                        o_in_range,
  output logic                        o_settled
);

  localparam int AW  = DATA_SIZE + LOG2_LEN;
  localparam int DCW = $clog2(DISCARD + 2);
  localparam logic [DCW-1:0]     DISC_LAST = DCW'((DISCARD > 0) ? DISCARD - 1 : 0);
  localparam logic [DATA_SIZE:0] THR       = (DATA_SIZE + 1)'(THRESHOLD);
`ifdef AVG_ROUNDING_EN
  localparam logic signed [AW-1:0] RND = AW'(2 ** (LOG2_LEN - 1));
`else
  localparam logic signed [AW-1:0] RND = '0;
`endif

  typedef enum logic {ST_WARMUP, ST_ACCUM} state_t;
  localparam state_t ST_RESET = (DISCARD == 0) ? ST_ACCUM : ST_WARMUP;

  state_t                 state_q;
  logic [DCW-1:0]         disc_q;
  logic [LOG2_LEN-1:0]    cnt_q;
  logic signed [AW-1:0]   acc_q;

  logic signed [AW-1:0]        acc_d;
  logic signed [AW-1:0]        sum_r;
  logic signed [DATA_SIZE-1:0] avg;
  logic [DATA_SIZE:0]          avg_x;
  logic [DATA_SIZE:0]          mag;
  logic                        in_range;
  logic                        unused_lsbs;

  assign acc_d = acc_q + {{LOG2_LEN{i_relation[DATA_SIZE-1]}}, i_relation};
  assign sum_r = acc_d + RND;
  // Dropping the low bits is the arithmetic shift; the result always fits DATA_SIZE bits.
  assign avg   = sum_r[AW-1:LOG2_LEN];
  assign avg_x = {avg[DATA_SIZE-1], avg};
  assign mag   = avg_x[DATA_SIZE] ? -avg_x : avg_x;
  assign in_range    = (mag <= THR);
  assign unused_lsbs = ^sum_r[LOG2_LEN-1:0];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_RESET;
      disc_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      o_average  <= '0;
      o_valid    <= 1'b0;
      o_in_range <= 1'b0;
      o_settled  <= (DISCARD == 0);
    end else begin
      o_valid <= 1'b0;
      if (i_valid) begin
        case (state_q)
          ST_WARMUP: begin
            if (disc_q == DISC_LAST) begin
              state_q   <= ST_ACCUM;
              o_settled <= 1'b1;
            end else begin
              disc_q <= disc_q + DCW'(1);
            end
          end
          ST_ACCUM: begin
            cnt_q <= cnt_q + LOG2_LEN'(1);
            if (&cnt_q) begin
              acc_q      <= '0;
              o_average  <= avg;
              o_in_range <= in_range;
              o_valid    <= 1'b1;
            end else begin
              acc_q <= acc_d;
            end
          end
          default: state_q <= ST_RESET;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_monopulse_averager.sv
// Scoreboard bench for monopulse_averager: reference model pushes expected averages, negedge monitor compares.
module tb_monopulse_averager;

  localparam int          DS   = 64;
  localparam int          LL   = 2;
  localparam int          DISC = 3;
  localparam int unsigned THR  = 20;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 vld = 1'b0;
  logic signed [DS-1:0] rel = '0;
  logic signed [DS-1:0] o_average;
  logic                 o_valid, o_in_range, o_settled;

  monopulse_averager #(
    .DATA_SIZE(DS), .LOG2_LEN(LL), .DISCARD(DISC), .THRESHOLD(THR)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_relation(rel),
    .i_valid   (vld),
    .o_average (o_average),
    .o_valid   (o_valid),
    .o_in_range(o_in_range),
    .o_settled (o_settled)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DS-1:0] avg;
    logic          inr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  int                  disc_seen;
  int                  blk_n;
  logic signed [DS+1:0] blk_sum;
  logic                exp_settled;
  logic [DS-1:0]       hold_avg;
  logic                hold_inr;

  logic signed [DS-1:0] rd;
  bit                   rv;

  task automatic check(input string name, input logic [DS-1:0] act, input logic [DS-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    disc_seen   = 0;
    blk_n       = 0;
    blk_sum     = '0;
    exp_settled = 1'b0;
    hold_avg    = '0;
    hold_inr    = 1'b0;
    sb.delete();
  endtask

  task automatic model_accept(input logic signed [DS-1:0] d);
    logic signed [DS+1:0] s, q;
    exp_t e;
    if (disc_seen < DISC) begin
      disc_seen++;
      if (disc_seen == DISC) exp_settled = 1'b1;
    end else begin
      blk_sum += d;
      blk_n++;
      if (blk_n == (1 << LL)) begin
        s = blk_sum;
`ifdef AVG_ROUNDING_EN
        s = s + (1 << (LL - 1));
`endif
        q = s / (1 << LL);
        if ((s % (1 << LL)) != 0 && s < 0) q = q - 1;
        e.avg = q[DS-1:0];
        e.inr = (q >= -$signed(THR) && q <= $signed(THR));
        sb.push_back(e);
        blk_sum = '0;
        blk_n   = 0;
      end
    end
  endtask

  task automatic step(input bit v, input logic signed [DS-1:0] d);
    vld = v;
    rel = d;
    @(posedge clk);
    #1;
    if (v) model_accept(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $signed({$urandom, $urandom}));
  endtask

  task automatic do_reset(input int cyc);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < cyc; i++) begin
      vld = 1'b1;
      rel = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    vld   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("settled", {63'd0, o_settled}, {63'd0, exp_settled});
      if (o_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", {63'd0, o_valid}, '0);
        end else begin
          mon_e = sb.pop_front();
          check("average", o_average, mon_e.avg);
          check("in_range", {63'd0, o_in_range}, {63'd0, mon_e.inr});
          hold_avg = mon_e.avg;
          hold_inr = mon_e.inr;
        end
      end else begin
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("missing_valid", {63'd0, o_valid}, 64'd1);
        end
        check("average_held", o_average, hold_avg);
        check("in_range_held", {63'd0, o_in_range}, {63'd0, hold_inr});
      end
    end
  end

  initial begin
    model_reset();
    #2;
    mon_en = 1'b1;
    do_reset(4);
    idle(2);

    for (int i = 0; i < 3; i++) step(1'b1, 64'sd999);
    step(1'b1, 64'sd10);
    step(1'b1, 64'sd20);
    step(1'b1, 64'sd30);
    step(1'b1, 64'sd40);
    idle(3);

    step(1'b1, -64'sd1);
    step(1'b1, -64'sd1);
    step(1'b1, -64'sd1);
    step(1'b1, -64'sd2);
    idle(2);

    step(1'b1, -64'sd1); idle(5);
    step(1'b1, -64'sd1); idle(5);
    step(1'b1, -64'sd1); idle(5);
    step(1'b1, -64'sd2); idle(5);

    for (int i = 0; i < 4; i++) step(1'b1, 64'sh7FFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 4; i++) step(1'b1, 64'sh8000_0000_0000_0000);
    idle(2);

    step(1'b1, 64'sd7);
    step(1'b1, 64'sd9);
    do_reset(1);
    for (int i = 0; i < 3; i++) step(1'b1, 64'sd555);
    for (int i = 0; i < 4; i++) step(1'b1, 64'sd4);
    idle(2);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset(1);
      rv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) rd = $signed({$urandom, $urandom});
      else rd = int'($urandom_range(0, 80)) - 40;
      step(rv, rd);
    end
    idle(3);

    check("scoreboard_empty", 64'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/monopulse_averager.md
# monopulse_averager

Post-processing stage directly downstream of the monopulse relation computation. Consumes the signed DATA_SIZE-bit relation stream, discards a fixed number of start-up samples while the upstream pipeline settles, then produces one block average per 2^LOG2_LEN accepted samples. Each average is flagged as in range when its magnitude is within a programmable on-boresight threshold. Outputs feed the tracking/indicator logic at top level.

## Interface

- DATA_SIZE, 64, width of relation input and average output (signed two's complement)
- LOG2_LEN, 4, log2 of samples per averaging block (block length N = 2^LOG2_LEN, LOG2_LEN ≥ 1)
- DISCARD, 8, number of accepted samples ignored after each reset (0 = none)
- THRESHOLD, 1024, non-negative in-range limit on |average|

- i_clock  input  1  sole clock; all state on rising edge
- i_reset  input  1  asynchronous, active-low reset
- i_relation  input  DATA_SIZE  signed relation sample
- i_valid  input  1  i_relation is a sample this cycle (tie high for a free-running source)
- o_average  output  DATA_SIZE  signed block average, held until next block
- o_valid  output  1  one-cycle pulse, o_average/o_in_range updated this cycle
- o_in_range  output  1  |o_average| ≤ THRESHOLD
- o_settled  output  1  high once warm-up is complete

## Operation

- States: ST_WARMUP, ST_ACCUM. Reset enters ST_WARMUP (ST_ACCUM directly if DISCARD = 0).
- ST_WARMUP: each i_valid increments a discard counter; samples not accumulated. On the DISCARD-th valid sample → ST_ACCUM, o_settled ← 1 next cycle.
- ST_ACCUM: accumulator width DATA_SIZE + LOG2_LEN, sign-extended adds; overflow impossible by construction.
- Sample counter LOG2_LEN bits, increments per valid sample, wraps N−1 → 0.
- On valid sample with counter = N−1: sum = acc + i_relation; o_average ← sum >>> LOG2_LEN (arithmetic, truncated to DATA_SIZE bits — always representable); acc ← 0; o_valid ← 1.
- o_in_range computed from the same sum: magnitude evaluated at DATA_SIZE+1 bits so the most-negative value is handled without wrap.
- i_valid low: no state changes; o_valid low.
- No back-pressure; every valid sample is accepted.
- Stays in ST_ACCUM until reset.

## Timing

- Reset values: o_average 0, o_valid 0, o_in_range 0, o_settled 0 (1 if DISCARD = 0), accumulator 0, counters 0.
- Latency: o_valid high in the cycle after the rising edge capturing the N-th sample of a block; low otherwise.
- Back-to-back blocks: with i_valid held high, o_valid pulses every N cycles.
- Transition sample: the DISCARD-th warm-up sample is discarded; the next valid sample is sample 0 of block 0.
- Reset mid-block or mid-warm-up: partial sums and counts lost immediately (asynchronous); warm-up restarts on release.
- o_average/o_in_range change only with o_valid.

## Configuration

- AVG_ROUNDING_EN defined: add 2^(LOG2_LEN−1) to sum before the arithmetic shift (round half toward +∞); in-range check uses the rounded value.
- Undefined: plain arithmetic shift (floor).

## Test plan

Bench parameters: DATA_SIZE=64, LOG2_LEN=2, DISCARD=3, THRESHOLD=20.
- Reset asserted with i_valid high and random data -> all outputs 0, no o_valid.
- Release, 3 samples of 999 then 10,20,30,40 -> 999s ignored, o_settled high after 3rd, o_average=25, o_in_range=0, single o_valid pulse one cycle after 40.
- Samples −1,−1,−1,−2 -> o_average=−2 without AVG_ROUNDING_EN, −1 with it; o_in_range=1 both.
- Same block with i_valid low for 5 cycles between each sample -> identical result, one o_valid pulse, none during gaps.
- Four samples of 2^63−1, then four of −2^63 -> o_average 2^63−1 (o_in_range 0), then −2^63 (o_in_range 0), no wrap.
- Two samples accepted, i_reset low one cycle, release -> outputs cleared, 3 samples discarded again, next block of 4,4,4,4 gives o_average=4.
